// File: rtl/multi_tick_generator.sv
// Multi-channel programmable tick generator: per-channel divisor, one-cycle tick
// enables and a 50% square wave, in periodic or one-shot mode, on one clock.
module multi_tick_generator #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      WIDTH       = 24,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = 24'd4194304,
    localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [WIDTH-1:0]  load_div,
    input  logic              load_oneshot,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] done
);

    logic [WIDTH-1:0]  div_q   [NUM_CH];
    logic [WIDTH-1:0]  div_d   [NUM_CH];
    logic [WIDTH-1:0]  cnt_q   [NUM_CH];
    logic [WIDTH-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] oneshot_q;
    logic [NUM_CH-1:0] oneshot_d;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] sq_d;
    logic [NUM_CH-1:0] done_d;
    logic [NUM_CH-1:0] load_sel;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] terminal;

    // Decode the write strobe; out-of-range addresses match no channel.
    always_comb begin
        load_sel = '0;
        active   = '0;
        terminal = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_sel[i] = load && (int'(load_ch) == i);
            active[i]   = en[i] && (div_q[i] != '0) && !done[i];
            terminal[i] = (cnt_q[i] == div_q[i] - WIDTH'(1));
        end
    end

    // Next-state: sync_clr beats load, load beats counting.
    always_comb begin
        tick_d    = '0;
        sq_d      = sq;
        done_d    = done;
        oneshot_d = oneshot_q;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_sel[i]) begin
                div_d[i]     = load_div;
                oneshot_d[i] = load_oneshot;
            end
            if (sync_clr || load_sel[i]) begin
                cnt_d[i]  = '0;
                sq_d[i]   = 1'b0;
                done_d[i] = 1'b0;
            end else if (active[i]) begin
                if (terminal[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq[i];
                    if (oneshot_q[i]) begin
                        done_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DEFAULT_DIV;
                cnt_q[i] <= '0;
            end
            oneshot_q <= '0;
            tick      <= '0;
            sq        <= '0;
            done      <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            oneshot_q <= oneshot_d;
            tick      <= tick_d;
            sq        <= sq_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Scoreboard bench for multi_tick_generator: expected tick events are queued with
// their cycle number; a negedge monitor pops one whenever any tick is high.
module tb_multi_tick_generator;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic              load = 1'b0;
    logic [CH_W-1:0]   load_ch = '0;
    logic [WIDTH-1:0]  load_div = '0;
    logic              load_oneshot = 1'b0;
    logic              sync_clr = 1'b0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] done;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] t;
        logic [NUM_CH-1:0] s;
        logic [NUM_CH-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    multi_tick_generator #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (8'd8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .load         (load),
        .load_ch      (load_ch),
        .load_div     (load_div),
        .load_oneshot (load_oneshot),
        .sync_clr     (sync_clr),
        .tick         (tick),
        .sq           (sq),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [NUM_CH-1:0] act, logic [NUM_CH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(int c, logic [NUM_CH-1:0] t, logic [NUM_CH-1:0] s, logic [NUM_CH-1:0] d);
        exp_t e;
        e.cyc = c; e.t = t; e.s = s; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        en       = '0;
        load     = 1'b0;
        sync_clr = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    // One-edge configuration write; leaves cyc at the edge that took it.
    task automatic write_cfg(logic [CH_W-1:0] ch, logic [WIDTH-1:0] n, logic os);
        load_ch      = ch;
        load_div     = n;
        load_oneshot = os;
        load         = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Monitor: any tick must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tick !== '0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tick: got tick=%b sq=%b at cycle %0d, none expected",
                             tick, sq, cyc);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (cyc != e.cyc) begin
                        bad++;
                        $display("FAIL tick_cycle: tick=%b at cycle %0d, want cycle %0d", tick, cyc, e.cyc);
                    end
                    check("tick_vec", tick, e.t);
                    check("sq_vec", sq, e.s);
                    check("done_vec", done, e.d);
                end
            end
        end
    end

    initial begin
        int k;
        int k2;
        int s;

        // Reset state and periodic ch0, N=4
        do_reset();
        check("reset_tick", tick, 5'b00000);
        check("reset_sq", sq, 5'b00000);
        check("reset_done", done, 5'b00000);
        en = 5'b00001;
        write_cfg(3'd0, 8'd4, 1'b0);
        k = cyc;
        push(k + 4,  5'b00001, 5'b00001, 5'b00000);
        push(k + 8,  5'b00001, 5'b00000, 5'b00000);
        push(k + 12, 5'b00001, 5'b00001, 5'b00000);
        run_to(k + 13);
        en = '0;
        repeat (2) step();

        // One-shot ch1, N=3, then reload
        do_reset();
        en = 5'b00010;
        write_cfg(3'd1, 8'd3, 1'b1);
        k = cyc;
        push(k + 3, 5'b00010, 5'b00010, 5'b00010);
        run_to(k + 23);
        check("oneshot_done_held", done, 5'b00010);
        write_cfg(3'd1, 8'd3, 1'b1);
        k2 = cyc;
        check("reload_done_clr", done, 5'b00000);
        check("reload_sq_clr", sq, 5'b00000);
        push(k2 + 3, 5'b00010, 5'b00010, 5'b00010);
        run_to(k2 + 6);

        // Pause ch2, N=5: 2 enabled edges, 7 paused, tick 3 enabled edges later
        do_reset();
        en = 5'b00100;
        write_cfg(3'd2, 8'd5, 1'b0);
        k = cyc;
        run_to(k + 2);
        en = '0;
        run_to(k + 9);
        en = 5'b00100;
        push(k + 12, 5'b00100, 5'b00100, 5'b00000);
        run_to(k + 14);
        en = '0;
        step();

        // ch0 N=4 and ch3 N=6, then sync_clr
        do_reset();
        en = 5'b01001;
        write_cfg(3'd0, 8'd4, 1'b0);
        k = cyc;
        write_cfg(3'd3, 8'd6, 1'b0);
        push(k + 4, 5'b00001, 5'b00001, 5'b00000);
        push(k + 7, 5'b01000, 5'b01001, 5'b00000);
        push(k + 8, 5'b00001, 5'b01000, 5'b00000);
        run_to(k + 9);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        s = cyc;
        check("sync_clr_sq", sq, 5'b00000);
        push(s + 4, 5'b00001, 5'b00001, 5'b00000);
        push(s + 6, 5'b01000, 5'b01001, 5'b00000);
        push(s + 8, 5'b00001, 5'b01000, 5'b00000);
        run_to(s + 9);
        en = '0;
        step();

        // Out-of-range load leaves ch0..ch3 at the default divisor of 8
        do_reset();
        write_cfg(3'd5, 8'd2, 1'b1);
        k = cyc;
        en = 5'b01111;
        push(k + 8,  5'b01111, 5'b01111, 5'b00000);
        push(k + 16, 5'b01111, 5'b00000, 5'b00000);
        run_to(k + 17);
        en = '0;

        // ch4: N=0 never ticks, N=1 ticks every cycle
        en = 5'b10000;
        write_cfg(3'd4, 8'd0, 1'b0);
        k = cyc;
        run_to(k + 10);
        write_cfg(3'd4, 8'd1, 1'b0);
        k2 = cyc;
        for (int i = 1; i <= 6; i++) begin
            push(k2 + i, 5'b10000, (i % 2 == 1) ? 5'b10000 : 5'b00000, 5'b00000);
        end
        run_to(k2 + 6);
        en = '0;
        repeat (2) step();

        // Asynchronous reset between edges, then default-divisor restart
        do_reset();
        en = 5'b00010;
        write_cfg(3'd1, 8'd2, 1'b1);
        k = cyc;
        push(k + 2, 5'b00010, 5'b00010, 5'b00010);
        run_to(k + 3);
        en = 5'b00011;
        write_cfg(3'd0, 8'd3, 1'b0);
        k2 = cyc;
        push(k2 + 3, 5'b00001, 5'b00011, 5'b00010);
        run_to(k2 + 3);
        #6;
        reset_n = 1'b0;
        #1;
        check("async_rst_tick", tick, 5'b00000);
        check("async_rst_sq", sq, 5'b00000);
        check("async_rst_done", done, 5'b00000);
        en = '0;
        step();
        reset_n = 1'b1;
        en = 5'b00001;
        k = cyc;
        push(k + 8, 5'b00001, 5'b00001, 5'b00000);
        run_to(k + 10);
        en = '0;
        step();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_ticks: %0d expected ticks never seen, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
